// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 single-wire link: decoder FSM states and
// default pulse timing shared with the transmitter.
package ws2812_pkg;

   localparam int unsigned CNT_W         = 12;
   localparam int unsigned T1_MIN_CYC    = 30;
   localparam int unsigned THIGH_MIN_CYC = 5;
   localparam int unsigned THIGH_MAX_CYC = 60;
   localparam int unsigned TRESET_CYC    = 2500;

   typedef enum logic [1:0] {
      StSync,
      StIdle,
      StHigh,
      StLow
   } state_e;

   // Saturating increment for the pulse-length counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both stages reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/ws2812_rx_decoder.sv
// WS2812 NRZ receiver: classifies high-pulse widths into bits, assembles MSB-first
// words and flags latch gaps and protocol errors with one-cycle strobes.
module ws2812_rx_decoder
   import ws2812_pkg::*;
#(
   parameter int unsigned W             = 24,
   parameter int unsigned T1_MIN_CYC    = ws2812_pkg::T1_MIN_CYC,
   parameter int unsigned THIGH_MIN_CYC = ws2812_pkg::THIGH_MIN_CYC,
   parameter int unsigned THIGH_MAX_CYC = ws2812_pkg::THIGH_MAX_CYC,
   parameter int unsigned TRESET_CYC    = ws2812_pkg::TRESET_CYC
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         din,
   output logic [W-1:0] data,
   output logic         valid,
   output logic         latch,
   output logic         err,
   output logic [4:0]   bit_idx
);

   localparam logic [CNT_W-1:0] T1_C     = CNT_W'(T1_MIN_CYC);
   localparam logic [CNT_W-1:0] TMIN_C   = CNT_W'(THIGH_MIN_CYC);
   localparam logic [CNT_W-1:0] TOVER_C  = CNT_W'(THIGH_MAX_CYC + 1);
   localparam logic [CNT_W-1:0] TRESET_C = CNT_W'(TRESET_CYC);
   localparam logic [4:0]       LAST_IDX = 5'(W - 1);

   logic s, s_d, rise, fall;

   logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
   state_e           state_q, state_d;
   logic [W-1:0]     shreg_q, shreg_d, data_q, data_d, shreg_next;
   logic [W:0]       shifted;
   logic [4:0]       idx_q, idx_d;
   logic             valid_q, valid_d, latch_q, latch_d, err_q, err_d;
   logic             bit_val;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (s)
   );

   assign rise = s & ~s_d;
   assign fall = ~s & s_d;

   // Each counter runs while the line holds its level and clears on the other level.
   assign hcnt_d = s ? sat_inc(hcnt_q) : '0;
   assign lcnt_d = s ? '0 : sat_inc(lcnt_q);

   assign bit_val    = (hcnt_q >= T1_C);
   assign shifted    = {shreg_q, bit_val};
   assign shreg_next = shifted[W-1:0];

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      idx_d   = idx_q;
      valid_d = 1'b0;
      latch_d = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         StSync: begin
            if (lcnt_q == TRESET_C) state_d = StIdle;
         end
         StIdle: begin
            if (rise) state_d = StHigh;
         end
         StHigh: begin
            if (s && hcnt_q == TOVER_C) begin
               err_d   = 1'b1;
               idx_d   = '0;
               shreg_d = '0;
               state_d = StSync;
            end else if (fall) begin
               if (hcnt_q < TMIN_C) begin
                  err_d   = 1'b1;
                  idx_d   = '0;
                  shreg_d = '0;
                  state_d = StSync;
               end else begin
                  shreg_d = shreg_next;
                  state_d = StLow;
                  if (idx_q == LAST_IDX) begin
                     data_d  = shreg_next;
                     valid_d = 1'b1;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 5'd1;
                  end
               end
            end
         end
         StLow: begin
            if (rise) begin
               state_d = StHigh;
            end else if (lcnt_q == TRESET_C) begin
               latch_d = 1'b1;
               err_d   = (idx_q != '0);
               idx_d   = '0;
               shreg_d = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StSync;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_d     <= 1'b0;
         hcnt_q  <= '0;
         lcnt_q  <= '0;
         state_q <= StSync;
         shreg_q <= '0;
         data_q  <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         latch_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         s_d     <= s;
         hcnt_q  <= hcnt_d;
         lcnt_q  <= lcnt_d;
         state_q <= state_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         latch_q <= latch_d;
         err_q   <= err_d;
      end
   end

   assign data    = data_q;
   assign valid   = valid_q;
   assign latch   = latch_q;
   assign err     = err_q;
   assign bit_idx = idx_q;

endmodule
